// File: rtl/trim_pkg.sv
// ============================================================================
// Module : trim_pkg
// Brief  : Shared constants and FSM state type for the trim stream receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package trim_pkg;
  localparam int TRIM_W       = 12;
  localparam int TRIM_TIMEOUT = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } trim_rx_st_t;
endpackage

`default_nettype wire

// File: rtl/trim_edge_sync.sv
// ============================================================================
// Module : trim_edge_sync
// Brief  : ENCLK rising-edge detector with optional 2-flop input synchronisers
//          (enabled by macro TRIM_RX_SYNC_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module trim_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enclk_i,
  input  logic dout_i,
  output logic edge_o,
  output logic din_o
);
  logic enc_s;
  logic din_s;
  logic enc_d_q;

`ifdef TRIM_RX_SYNC_EN
  logic [1:0] enc_sync_q;
  logic [1:0] din_sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enc_sync_q <= 2'b00;
      din_sync_q <= 2'b00;
    end else begin
      enc_sync_q <= {enc_sync_q[0], enclk_i};
      din_sync_q <= {din_sync_q[0], dout_i};
    end
  end

  assign enc_s = enc_sync_q[1];
  assign din_s = din_sync_q[1];
`else
  assign enc_s = enclk_i;
  assign din_s = dout_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enc_d_q <= 1'b0;
    end else begin
      enc_d_q <= enc_s;
    end
  end

  assign edge_o = enc_s & ~enc_d_q;
  assign din_o  = din_s;
endmodule

`default_nettype wire

// File: rtl/trim_rx.sv
// ============================================================================
// Module : trim_rx
// Brief  : Serial trim-stream receiver; rebuilds WIDTH-bit frames into a held
//          TRIM_CODE word. Input synchronisers selected by TRIM_RX_SYNC_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module trim_rx
  import trim_pkg::*;
#(
  parameter int WIDTH     = TRIM_W,
  parameter int TIMEOUT   = TRIM_TIMEOUT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK50,
  input  logic             RST,
  input  logic             DOUT,
  input  logic             ENCLK,
  output logic [WIDTH-1:0] TRIM_CODE,
  output logic             TRIM_VLD,
  output logic             BUSY,
  output logic             FRAME_ERR
);
  localparam int BCW = $clog2(WIDTH);
  localparam int TCW = $clog2(TIMEOUT);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [TCW-1:0] T_LAST   = TCW'(TIMEOUT - 1);

  logic enc_edge;
  logic din_s;

  trim_edge_sync u_edge (
    .clk_i   (CLK50),
    .rst_i   (RST),
    .enclk_i (ENCLK),
    .dout_i  (DOUT),
    .edge_o  (enc_edge),
    .din_o   (din_s)
  );

  trim_rx_st_t      state_q;
  logic [BCW-1:0]   bitcnt_q;
  logic [TCW-1:0]   tcnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] code_q;
  logic             vld_q;
  logic             err_q;
  logic             busy_q;

  // The first captured bit travels to the MSB (MSB_FIRST) or the LSB end.
  always_comb begin
    shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], din_s} : {din_s, shift_q[WIDTH-1:1]};
  end

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      tcnt_q   <= '0;
      shift_q  <= '0;
      code_q   <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enc_edge) begin
            shift_q  <= shift_d;
            bitcnt_q <= BCW'(1);
            tcnt_q   <= '0;
            state_q  <= SHIFT;
            busy_q   <= 1'b1;
          end
        end
        SHIFT: begin
          if (enc_edge) begin
            shift_q <= shift_d;
            tcnt_q  <= '0;
            if (bitcnt_q == BIT_LAST) begin
              code_q   <= shift_d;
              vld_q    <= 1'b1;
              bitcnt_q <= '0;
              state_q  <= IDLE;
              busy_q   <= 1'b0;
            end else begin
              bitcnt_q <= bitcnt_q + BCW'(1);
            end
          end else if (tcnt_q == T_LAST) begin
            // An edge in this same cycle is handled above, so it beats the timeout.
            err_q    <= 1'b1;
            bitcnt_q <= '0;
            tcnt_q   <= '0;
            shift_q  <= '0;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end else begin
            tcnt_q <= tcnt_q + TCW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TRIM_CODE = code_q;
  assign TRIM_VLD  = vld_q;
  assign BUSY      = busy_q;
  assign FRAME_ERR = err_q;
endmodule

`default_nettype wire
